// File: rtl/avl_meter.sv
// avl_meter: audio level meter with an N-LED bar/dot display, peak-hold with
// timed decay, and a multiplexed common-anode 7-segment readout of the peak.
module avl_meter #(
  parameter int LED_N        = 16,
  parameter int LEVEL_W      = 5,
  parameter int DIGITS       = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int DECAY_CYCLES = 5_000_000
) (
  input  logic               CLOCK,
  input  logic               RESETN,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_valid,
  input  logic               mode,
  input  logic               freeze,
  output logic [LED_N-1:0]   led,
  output logic [DIGITS-1:0]  an,
  output logic [7:0]         seg
);

  localparam int TMR_MAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TMR_W-1:0]   HOLD_LD   = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0]   DECAY_LD  = TMR_W'(DECAY_CYCLES);
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]   DIG_LAST  = DIG_W'(DIGITS - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LED_N);

  // Saturate an incoming sample to the number of bar LEDs.
  function automatic logic [LEVEL_W-1:0] f_clamp(input logic [LEVEL_W-1:0] v);
    return (v > LVL_MAX) ? LVL_MAX : v;
  endfunction

  // Active-low segment pattern (dp off) for one decimal digit.
  function automatic logic [7:0] f_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int f_pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  logic [LEVEL_W-1:0] r_cur;
  logic [LEVEL_W-1:0] r_peak;
  logic [TMR_W-1:0]   r_tmr;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [DIG_W-1:0]   r_dig;

  logic [LEVEL_W-1:0] w_s;
  logic               w_acc;
  logic [LEVEL_W-1:0] w_cur_nxt;
  logic [LED_N-1:0]   w_led;
  logic [7:0]         w_glyph [DIGITS];

  assign w_s       = f_clamp(level);
  assign w_acc     = level_valid & ~freeze;
  assign w_cur_nxt = w_acc ? w_s : r_cur;

  // Current level capture plus peak-hold / decay timer; a capture at or above
  // the peak always wins, freeze stalls the timer, and decay stops at cur.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      r_cur  <= '0;
      r_peak <= '0;
      r_tmr  <= '0;
    end else begin
      r_cur <= w_cur_nxt;
      if (w_acc && (w_s >= r_peak)) begin
        r_peak <= w_s;
        r_tmr  <= HOLD_LD;
      end else if (!freeze) begin
        if (r_tmr != '0) begin
          r_tmr <= r_tmr - 1'b1;
        end else if (r_peak > w_cur_nxt) begin
          r_peak <= r_peak - 1'b1;
          r_tmr  <= DECAY_LD;
        end
      end
    end
  end

  // Bar fills everything below cur, dot lights only the cur LED; the peak LED
  // is overlaid in both modes. A zero level maps to index -1, i.e. no LED.
  always_comb begin
    w_led = '0;
    for (int i = 0; i < LED_N; i++) begin
      w_led[i] = (mode ? (i == int'(r_cur) - 1) : (i < int'(r_cur)))
               || (i == int'(r_peak) - 1);
    end
  end

  // Per-digit glyph of the peak value; non-units digits above the most
  // significant non-zero digit are blanked.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    localparam int P = f_pow10(k);
    assign w_glyph[k] = ((k != 0) && (int'(r_peak) < P)) ? 8'hFF
                        : f_glyph(4'((int'(r_peak) / P) % 10));
  end

  // Digit scan: each position is held for SCAN_DIV cycles before advancing.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      r_scan_cnt <= '0;
      r_dig      <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_dig      <= (r_dig == DIG_LAST) ? '0 : r_dig + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Registered pin drive for LEDs, anodes and segments.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      led <= '0;
      an  <= '1;
      seg <= 8'hFF;
    end else begin
      led <= w_led;
      an  <= ~(DIGITS'(1) << r_dig);
      seg <= w_glyph[r_dig];
    end
  end

endmodule

// File: tb/tb_avl_meter.sv
// Bench for avl_meter: a cycle model queues the expected pin state for every
// clock edge and each scenario task pops and compares it, plus fixed checks.
module tb_avl_meter;

  localparam int LED_N   = 16;
  localparam int LEVEL_W = 5;
  localparam int DIGITS  = 2;
  localparam int SCAN    = 4;
  localparam int HOLD    = 8;
  localparam int DECAY   = 3;

  typedef struct packed {
    logic [LED_N-1:0]  led;
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;
  } exp_t;

  logic               CLOCK = 1'b0;
  logic               RESETN = 1'b0;
  logic [LEVEL_W-1:0] level = '0;
  logic               level_valid = 1'b0;
  logic               mode = 1'b0;
  logic               freeze = 1'b0;
  logic [LED_N-1:0]   led;
  logic [DIGITS-1:0]  an;
  logic [7:0]         seg;

  int   vec = 0;
  int   miss = 0;
  exp_t q[$];
  int   m_cur = 0, m_peak = 0, m_tmr = 0, m_cnt = 0, m_dig = 0;

  avl_meter #(
    .LED_N(LED_N), .LEVEL_W(LEVEL_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN),
    .HOLD_CYCLES(HOLD), .DECAY_CYCLES(DECAY)
  ) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .level(level), .level_valid(level_valid),
    .mode(mode), .freeze(freeze), .led(led), .an(an), .seg(seg)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [7:0] glyph(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  // One clock edge: queue what the pins must show after it, then advance the model.
  task automatic tick();
    exp_t e;
    int s, nc;
    bit acc;
    if (!RESETN) begin
      e.led = '0; e.an = '1; e.seg = 8'hFF;
    end else begin
      e.led = '0;
      if (!mode) begin
        for (int i = 0; i < m_cur; i++) e.led[i] = 1'b1;
      end else if (m_cur != 0) begin
        e.led[m_cur-1] = 1'b1;
      end
      if (m_peak != 0) e.led[m_peak-1] = 1'b1;
      e.an = '1;
      e.an[m_dig] = 1'b0;
      if (m_dig == 0) e.seg = glyph(m_peak % 10);
      else            e.seg = (m_peak < 10) ? 8'hFF : glyph((m_peak / 10) % 10);
    end
    q.push_back(e);
    @(posedge CLOCK);
    if (!RESETN) begin
      m_cur = 0; m_peak = 0; m_tmr = 0; m_cnt = 0; m_dig = 0;
    end else begin
      s   = (int'(level) > LED_N) ? LED_N : int'(level);
      acc = level_valid && !freeze;
      nc  = acc ? s : m_cur;
      if (acc && s >= m_peak) begin
        m_peak = s; m_tmr = HOLD;
      end else if (!freeze) begin
        if (m_tmr != 0) m_tmr = m_tmr - 1;
        else if (m_peak > nc) begin m_peak = m_peak - 1; m_tmr = DECAY; end
      end
      m_cur = nc;
      if (m_cnt == SCAN - 1) begin m_cnt = 0; m_dig = (m_dig + 1) % DIGITS; end
      else m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic apply_reset();
    exp_t e;
    RESETN = 1'b0; level_valid = 1'b0; freeze = 1'b0;
    tick();
    e = q.pop_front();
    RESETN = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    RESETN = 1'b0; level_valid = 1'b1; level = 5'd9; mode = 1'b0; freeze = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin RESETN = 1'b1; level_valid = 1'b0; end
      tick();
      e = q.pop_front();
      vec += 3;
      if (led !== e.led) begin miss++; $display("FAIL reset led c=%0d got %h want %h", c, led, e.led); end
      if (an  !== e.an)  begin miss++; $display("FAIL reset an c=%0d got %b want %b", c, an, e.an); end
      if (seg !== e.seg) begin miss++; $display("FAIL reset seg c=%0d got %h want %h", c, seg, e.seg); end
      vec++;
      if (c < 3 && {led, an, seg} !== {16'h0, 2'b11, 8'hFF}) begin
        miss++; $display("FAIL reset_pins c=%0d got %h/%b/%h want 0000/11/ff", c, led, an, seg);
      end
      if (c == 3 && {led, an, seg} !== {16'h0, 2'b10, 8'hC0}) begin
        miss++; $display("FAIL reset_release got %h/%b/%h want 0000/10/c0", led, an, seg);
      end
    end
  endtask

  task automatic test_bar_clamp();
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin level = 5'd5;  level_valid = 1'b1; end
      if (c == 1) level_valid = 1'b0;
      if (c == 6) begin level = 5'd20; level_valid = 1'b1; end
      if (c == 7) level_valid = 1'b0;
      tick();
      e = q.pop_front();
      vec += 3;
      if (led !== e.led) begin miss++; $display("FAIL bar led c=%0d got %h want %h", c, led, e.led); end
      if (an  !== e.an)  begin miss++; $display("FAIL bar an c=%0d got %b want %b", c, an, e.an); end
      if (seg !== e.seg) begin miss++; $display("FAIL bar seg c=%0d got %h want %h", c, seg, e.seg); end
      if (c >= 1 && c <= 6) begin
        vec += 2;
        if (led !== 16'h001F) begin miss++; $display("FAIL bar5_led got %h want 001f", led); end
        if (seg !== ((an == 2'b10) ? 8'h92 : 8'hFF)) begin
          miss++; $display("FAIL bar5_seg an=%b got %h want %h", an, seg, (an == 2'b10) ? 8'h92 : 8'hFF);
        end
      end
      if (c >= 7) begin
        vec += 2;
        if (led !== 16'hFFFF) begin miss++; $display("FAIL clamp_led got %h want ffff", led); end
        if (seg !== ((an == 2'b10) ? 8'h82 : 8'hF9)) begin
          miss++; $display("FAIL clamp_seg an=%b got %h want %h", an, seg, (an == 2'b10) ? 8'h82 : 8'hF9);
        end
      end
    end
  endtask

  task automatic test_hold_decay();
    exp_t e;
    apply_reset();
    mode = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k == 0) begin level = 5'd10; level_valid = 1'b1; end
      if (k == 1) level = 5'd3;
      if (k == 2) level_valid = 1'b0;
      tick();
      e = q.pop_front();
      vec += 3;
      if (led !== e.led) begin miss++; $display("FAIL decay led k=%0d got %h want %h", k, led, e.led); end
      if (an  !== e.an)  begin miss++; $display("FAIL decay an k=%0d got %b want %b", k, an, e.an); end
      if (seg !== e.seg) begin miss++; $display("FAIL decay seg k=%0d got %h want %h", k, seg, e.seg); end
      if (k == 9)  begin vec++; if (led[9] !== 1'b1) begin miss++; $display("FAIL hold_end got %h want bit9", led); end end
      if (k == 10) begin vec++; if (led[9:8] !== 2'b01) begin miss++; $display("FAIL first_dec got %h want bit8", led); end end
      if (k == 13) begin vec++; if (led[8:7] !== 2'b10) begin miss++; $display("FAIL dec_gap got %h want bit8", led); end end
      if (k == 14) begin vec++; if (led[8:7] !== 2'b01) begin miss++; $display("FAIL second_dec got %h want bit7", led); end end
      if (k == 40) begin vec++; if (led !== 16'h0007) begin miss++; $display("FAIL decay_floor got %h want 0007", led); end end
    end
  endtask

  task automatic test_dot();
    exp_t e;
    apply_reset();
    mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin level = 5'd9; level_valid = 1'b1; end
      if (k == 1) level = 5'd4;
      if (k == 2) level_valid = 1'b0;
      tick();
      e = q.pop_front();
      vec += 3;
      if (led !== e.led) begin miss++; $display("FAIL dot led k=%0d got %h want %h", k, led, e.led); end
      if (an  !== e.an)  begin miss++; $display("FAIL dot an k=%0d got %b want %b", k, an, e.an); end
      if (seg !== e.seg) begin miss++; $display("FAIL dot seg k=%0d got %h want %h", k, seg, e.seg); end
      if (k >= 2) begin vec++; if (led !== 16'h0108) begin miss++; $display("FAIL dot_map got %h want 0108", led); end end
    end
    apply_reset();
    tick();
    e = q.pop_front();
    vec += 2;
    if (led !== e.led) begin miss++; $display("FAIL dot_zero led got %h want %h", led, e.led); end
    if (led !== 16'h0000) begin miss++; $display("FAIL dot_zero_const got %h want 0000", led); end
    mode = 1'b0;
  endtask

  task automatic test_freeze();
    exp_t e;
    apply_reset();
    for (int k = 0; k <= 20; k++) begin
      if (k == 0) begin level = 5'd10; level_valid = 1'b1; end
      if (k == 1) level = 5'd3;
      if (k == 2) begin freeze = 1'b1; level = 5'd12; end
      if (k == 7) begin freeze = 1'b0; level_valid = 1'b0; end
      tick();
      e = q.pop_front();
      vec += 3;
      if (led !== e.led) begin miss++; $display("FAIL freeze led k=%0d got %h want %h", k, led, e.led); end
      if (an  !== e.an)  begin miss++; $display("FAIL freeze an k=%0d got %b want %b", k, an, e.an); end
      if (seg !== e.seg) begin miss++; $display("FAIL freeze seg k=%0d got %h want %h", k, seg, e.seg); end
      if (k >= 3 && k <= 7) begin vec++; if (led !== 16'h0207) begin miss++; $display("FAIL freeze_drop k=%0d got %h want 0207", k, led); end end
      if (k == 14) begin vec++; if (led[9:8] !== 2'b10) begin miss++; $display("FAIL freeze_hold got %h want bit9", led); end end
      if (k == 15) begin vec++; if (led[9:8] !== 2'b01) begin miss++; $display("FAIL freeze_dec got %h want bit8", led); end end
    end
  endtask

  task automatic test_scan_reset();
    exp_t e;
    logic [1:0] want;
    apply_reset();
    for (int c = 1; c <= 14; c++) begin
      if (c == 7) RESETN = 1'b0;
      if (c == 8) RESETN = 1'b1;
      tick();
      e = q.pop_front();
      vec += 3;
      if (led !== e.led) begin miss++; $display("FAIL scan led c=%0d got %h want %h", c, led, e.led); end
      if (an  !== e.an)  begin miss++; $display("FAIL scan an c=%0d got %b want %b", c, an, e.an); end
      if (seg !== e.seg) begin miss++; $display("FAIL scan seg c=%0d got %h want %h", c, seg, e.seg); end
      if (c <= 6)      want = (((c - 1) / SCAN) % 2 == 0) ? 2'b10 : 2'b01;
      else if (c == 7) want = 2'b11;
      else             want = (((c - 8) / SCAN) % 2 == 0) ? 2'b10 : 2'b01;
      vec++;
      if (an !== want) begin miss++; $display("FAIL scan_seq c=%0d got %b want %b", c, an, want); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      level       = 5'($urandom_range(0, 31));
      level_valid = 1'($urandom_range(0, 2) == 0);
      freeze      = 1'($urandom_range(0, 7) == 0);
      if (c % 50 == 0) mode = 1'($urandom_range(0, 1));
      tick();
      e = q.pop_front();
      vec += 3;
      if (led !== e.led) begin miss++; $display("FAIL b2b led c=%0d got %h want %h", c, led, e.led); end
      if (an  !== e.an)  begin miss++; $display("FAIL b2b an c=%0d got %b want %b", c, an, e.an); end
      if (seg !== e.seg) begin miss++; $display("FAIL b2b seg c=%0d got %h want %h", c, seg, e.seg); end
    end
    level_valid = 1'b0; freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bar_clamp();
    test_hold_decay();
    test_dot();
    test_freeze();
    test_scan_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
